// File: rtl/matrix_seq_pkg.sv
// Shared types and helpers for the matrix sequencer: state encoding, opcode
// constants, packed-word count and unary-opcode classification.
package matrix_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_LOAD_OPS,
        S_RUN,
        S_DUMP
    } state_e;

    localparam int unsigned OPC_NOP       = 0;
    localparam int unsigned OPC_TRANSPOSE = 3;
    localparam int unsigned OPC_SCALE     = 4;
    localparam int unsigned OPC_LOAD      = 6;
    localparam int unsigned OPC_STORE     = 7;

    function automatic int unsigned calc_words(input int unsigned dim, input int unsigned epw);
        return (dim * dim + epw - 1) / epw;
    endfunction

    function automatic logic is_unary(input int unsigned opc);
        return (opc == OPC_TRANSPOSE) || (opc == OPC_SCALE);
    endfunction

endpackage

// File: rtl/buffer_walker.sv
// Buffer/element counters for operand fetch and result dump, plus the
// memory address of the word currently being transferred.
module buffer_walker
    import matrix_seq_pkg::*;
#(
    parameter int unsigned DIM            = 5,
    parameter int unsigned ELEMS_PER_WORD = 2,
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned BUF_STRIDE     = 13
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [1:0]        load_id,
    input  logic              advance,
    output logic [1:0]        buf_id,
    output logic [4:0]        buf_index,
    output logic              last_word,
    output logic [ADDR_W-1:0] mem_address
);
    localparam int unsigned WORDS = calc_words(DIM, ELEMS_PER_WORD);

    logic [1:0] buf_id_d, buf_id_q;
    logic [4:0] buf_index_d, buf_index_q;

    assign last_word = (32'(buf_index_q) / ELEMS_PER_WORD) == (WORDS - 1);

    always_comb begin
        buf_id_d    = buf_id_q;
        buf_index_d = buf_index_q;
        if (load) begin
            buf_id_d    = load_id;
            buf_index_d = '0;
        end else if (advance) begin
            if (last_word) begin
                buf_index_d = '0;
                buf_id_d    = buf_id_q + 2'd1;
            end else begin
                buf_index_d = buf_index_q + 5'(ELEMS_PER_WORD);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            buf_id_q    <= '0;
            buf_index_q <= '0;
        end else begin
            buf_id_q    <= buf_id_d;
            buf_index_q <= buf_index_d;
        end
    end

    assign buf_id      = buf_id_q;
    assign buf_index   = buf_index_q;
    assign mem_address = ADDR_W'(32'(buf_id_q) * BUF_STRIDE + 32'(buf_index_q) / ELEMS_PER_WORD);

endmodule

// File: rtl/matrix_sequencer.sv
// Control sequencer: fetches operand buffers, runs the ALU, dumps the result.
// Optional MATSEQ_UNARY_SKIP_EN: unary opcodes fetch only buffer 0.
module matrix_sequencer
    import matrix_seq_pkg::*;
#(
    parameter int unsigned DIM            = 5,
    parameter int unsigned ELEMS_PER_WORD = 2,
    parameter int unsigned N_OPERANDS     = 2,
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned BUF_STRIDE     = 13,
    parameter int unsigned OPC_W          = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OPC_W-1:0]  instr_opcode,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic [DATA_W-1:0] instr_data,
    output logic [OPC_W-1:0]  alu_op,
    output logic              alu_start,
    input  logic              alu_done,
    output logic              mem_start,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    output logic [1:0]        buf_id,
    output logic [4:0]        buf_index,
    output logic              busy
);
    state_e            state_d, state_q;
    logic [OPC_W-1:0]  opc_d, opc_q, alu_op_d, alu_op_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic              mem_start_d, mem_start_q, mem_we_d, mem_we_q;
    logic              alu_start_d, alu_start_q, ready_d, ready_q, busy_d, busy_q;
    logic              fin_d, fin_q;

    logic              walk_load, walk_adv, w_last;
    logic [1:0]        walk_id, w_buf_id, load_last;
    logic [4:0]        w_buf_index;
    logic [ADDR_W-1:0] w_addr;

    buffer_walker #(
        .DIM            (DIM),
        .ELEMS_PER_WORD (ELEMS_PER_WORD),
        .ADDR_W         (ADDR_W),
        .BUF_STRIDE     (BUF_STRIDE)
    ) u_walker (
        .clock       (clock),
        .reset_n     (reset_n),
        .load        (walk_load),
        .load_id     (walk_id),
        .advance     (walk_adv),
        .buf_id      (w_buf_id),
        .buf_index   (w_buf_index),
        .last_word   (w_last),
        .mem_address (w_addr)
    );

`ifdef MATSEQ_UNARY_SKIP_EN
    assign load_last = is_unary(32'(opc_q)) ? 2'd0 : 2'(N_OPERANDS - 1);
`else
    assign load_last = 2'(N_OPERANDS - 1);
`endif

    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        alu_op_d    = alu_op_q;
        mem_start_d = mem_start_q;
        mem_we_d    = mem_we_q;
        alu_start_d = alu_start_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        fin_d       = fin_q;
        walk_load   = 1'b0;
        walk_adv    = 1'b0;
        walk_id     = '0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    opc_d   = instr_opcode;
                    addr_d  = instr_addr;
                    wdata_d = instr_data;
                    if (instr_opcode == OPC_W'(OPC_LOAD) || instr_opcode == OPC_W'(OPC_STORE)) begin
                        state_d     = S_MEM;
                        mem_start_d = 1'b1;
                        mem_we_d    = (instr_opcode == OPC_W'(OPC_STORE));
                        ready_d     = 1'b0;
                        busy_d      = 1'b1;
                    end else if (instr_opcode != OPC_W'(OPC_NOP)) begin
                        state_d     = S_LOAD_OPS;
                        mem_start_d = 1'b1;
                        mem_we_d    = 1'b0;
                        ready_d     = 1'b0;
                        busy_d      = 1'b1;
                        fin_d       = 1'b0;
                        walk_load   = 1'b1;
                    end
                end
            end
            S_MEM: begin
                if (mem_done) begin
                    state_d     = S_IDLE;
                    mem_start_d = 1'b0;
                    mem_we_d    = 1'b0;
                    ready_d     = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            S_LOAD_OPS, S_DUMP: begin
                // fin_q marks that the word just completed was the final one,
                // so the one-cycle gap after it becomes the phase exit.
                if (mem_start_q) begin
                    if (mem_done) begin
                        mem_start_d = 1'b0;
                        walk_adv    = 1'b1;
                        fin_d       = w_last && (state_q == S_DUMP || w_buf_id == load_last);
                    end
                end else if (fin_q) begin
                    fin_d     = 1'b0;
                    walk_load = 1'b1;
                    if (state_q == S_LOAD_OPS) begin
                        state_d     = S_RUN;
                        alu_start_d = 1'b1;
                        alu_op_d    = opc_q;
                        walk_id     = 2'(N_OPERANDS);
                    end else begin
                        state_d  = S_IDLE;
                        mem_we_d = 1'b0;
                        ready_d  = 1'b1;
                        busy_d   = 1'b0;
                    end
                end else begin
                    mem_start_d = 1'b1;
                end
            end
            S_RUN: begin
                if (alu_done) begin
                    state_d     = S_DUMP;
                    alu_start_d = 1'b0;
                    alu_op_d    = '0;
                    mem_start_d = 1'b1;
                    mem_we_d    = 1'b1;
                    walk_load   = 1'b1;
                    walk_id     = 2'(N_OPERANDS);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            opc_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            alu_op_q    <= '0;
            mem_start_q <= 1'b0;
            mem_we_q    <= 1'b0;
            alu_start_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            alu_op_q    <= alu_op_d;
            mem_start_q <= mem_start_d;
            mem_we_q    <= mem_we_d;
            alu_start_q <= alu_start_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            fin_q       <= fin_d;
        end
    end

    assign instr_ready  = ready_q;
    assign busy         = busy_q;
    assign alu_op       = alu_op_q;
    assign alu_start    = alu_start_q;
    assign mem_start    = mem_start_q;
    assign mem_write_en = mem_we_q;
    assign mem_wdata    = wdata_q;
    assign buf_id       = w_buf_id;
    assign buf_index    = w_buf_index;
    assign mem_address  = (state_q == S_LOAD_OPS || state_q == S_DUMP) ? w_addr : addr_q;

endmodule

// File: tb/tb_matrix_sequencer.sv
// Scoreboard bench for matrix_sequencer: default-parameter instance plus a
// DIM=4 / 4-per-word / 3-operand instance; expected transfers are queued at issue.
module tb_matrix_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        reset_n, instr_valid, instr_valid2;
    logic [3:0]  instr_opcode;
    logic [5:0]  instr_addr;
    logic [15:0] instr_data;

    logic        instr_ready, alu_start, alu_done, mem_start, mem_write_en, mem_done, busy;
    logic [3:0]  alu_op;
    logic [5:0]  mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  buf_id;
    logic [4:0]  buf_index;

    logic        instr_ready2, alu_start2, alu_done2, mem_start2, mem_write_en2, mem_done2, busy2;
    logic [3:0]  alu_op2;
    logic [5:0]  mem_address2;
    logic [15:0] mem_wdata2;
    logic [1:0]  buf_id2;
    logic [4:0]  buf_index2;

    matrix_sequencer u_dut (
        .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_addr(instr_addr), .instr_data(instr_data),
        .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
        .mem_start(mem_start), .mem_write_en(mem_write_en), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .buf_id(buf_id), .buf_index(buf_index),
        .busy(busy)
    );

    matrix_sequencer #(
        .DIM(4), .ELEMS_PER_WORD(4), .N_OPERANDS(3), .BUF_STRIDE(8)
    ) u_dut2 (
        .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid2), .instr_ready(instr_ready2),
        .instr_opcode(instr_opcode), .instr_addr(instr_addr), .instr_data(instr_data),
        .alu_op(alu_op2), .alu_start(alu_start2), .alu_done(alu_done2),
        .mem_start(mem_start2), .mem_write_en(mem_write_en2), .mem_address(mem_address2),
        .mem_wdata(mem_wdata2), .mem_done(mem_done2), .buf_id(buf_id2), .buf_index(buf_index2),
        .busy(busy2)
    );

    // Zero-wait memory and single-cycle ALU for the second instance.
    assign mem_done2 = mem_start2;
    assign alu_done2 = alu_start2;

    typedef struct packed {
        logic        is_alu;
        logic        we;
        logic        chk_wd;
        logic [5:0]  addr;
        logic [1:0]  id;
        logic [4:0]  idx;
        logic [3:0]  op;
        logic [15:0] wd;
    } ev_t;

    ev_t exp_q[$];
    ev_t exp2_q[$];
    int  tests = 0;
    int  fails = 0;
    int unsigned t_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory/ALU responders for the first instance
    int unsigned t_mem = 1, t_alu = 1, mcnt = 0, acnt = 0;
    logic mdone_r = 1'b0, adone_r = 1'b0, mspur = 1'b0, aspur = 1'b0;
    assign mem_done = mdone_r | mspur;
    assign alu_done = adone_r | aspur;

    initial forever begin
        @(negedge clock);
        if (mem_start) begin mcnt++; mdone_r = (mcnt >= t_mem); end
        else begin mcnt = 0; mdone_r = 1'b0; end
        if (alu_start) begin acnt++; adone_r = (acnt >= t_alu); end
        else begin acnt = 0; adone_r = 1'b0; end
    end

    task automatic observe(input bit sel, input logic is_alu, input logic we, input logic [5:0] addr,
                           input logic [1:0] id, input logic [4:0] idx, input logic [3:0] op,
                           input logic [15:0] wd);
        ev_t e;
        int unsigned sz;
        string p;
        p  = sel ? "dut2_" : "dut1_";
        sz = sel ? exp2_q.size() : exp_q.size();
        check({p, "event_expected"}, 32'(sz != 0), 1);
        if (sz != 0) begin
            if (sel) e = exp2_q.pop_front();
            else     e = exp_q.pop_front();
            check({p, "event_kind"}, 32'(is_alu), 32'(e.is_alu));
            if (e.is_alu) begin
                check({p, "alu_op"}, 32'(op), 32'(e.op));
            end else begin
                check({p, "mem_address"}, 32'(addr), 32'(e.addr));
                check({p, "mem_write_en"}, 32'(we), 32'(e.we));
                check({p, "buf_id"}, 32'(id), 32'(e.id));
                check({p, "buf_index"}, 32'(idx), 32'(e.idx));
                if (e.chk_wd) check({p, "mem_wdata"}, 32'(mem_wdata), 32'(e.wd));
            end
        end
    endtask

    // Monitors: every rising request edge consumes one expected event
    logic ms1 = 1'b0, as1 = 1'b0, ms2 = 1'b0, as2 = 1'b0;
    initial forever begin
        @(negedge clock);
        if (reset_n && mem_start && !ms1)
            observe(0, 1'b0, mem_write_en, mem_address, buf_id, buf_index, alu_op, mem_wdata);
        if (reset_n && alu_start && !as1)
            observe(0, 1'b1, mem_write_en, mem_address, buf_id, buf_index, alu_op, mem_wdata);
        if (reset_n && mem_start2 && !ms2)
            observe(1, 1'b0, mem_write_en2, mem_address2, buf_id2, buf_index2, alu_op2, mem_wdata2);
        if (reset_n && alu_start2 && !as2)
            observe(1, 1'b1, mem_write_en2, mem_address2, buf_id2, buf_index2, alu_op2, mem_wdata2);
        ms1 = reset_n && mem_start;
        as1 = reset_n && alu_start;
        ms2 = reset_n && mem_start2;
        as2 = reset_n && alu_start2;
    end

    task automatic push_mem(input bit sel, input logic we, input int unsigned addr, input int unsigned id,
                            input int unsigned idx, input logic chk, input logic [15:0] wd);
        ev_t e;
        e = '0;
        e.we = we; e.addr = 6'(addr); e.id = 2'(id); e.idx = 5'(idx); e.chk_wd = chk; e.wd = wd;
        if (sel) exp2_q.push_back(e);
        else     exp_q.push_back(e);
    endtask

    task automatic push_alu(input bit sel, input int unsigned op);
        ev_t e;
        e = '0;
        e.is_alu = 1'b1; e.op = 4'(op);
        if (sel) exp2_q.push_back(e);
        else     exp_q.push_back(e);
    endtask

    // Default instance: 13 words per buffer, stride 13, result buffer 2
    task automatic push_alu_seq(input int unsigned op, input int unsigned nbuf);
        for (int unsigned b = 0; b < nbuf; b++)
            for (int unsigned w = 0; w < 13; w++)
                push_mem(0, 1'b0, b * 13 + w, b, w * 2, 1'b0, 16'h0);
        push_alu(0, op);
        for (int unsigned w = 0; w < 13; w++)
            push_mem(0, 1'b1, 26 + w, 2, w * 2, 1'b0, 16'h0);
    endtask

    task automatic issue(input bit sel, input logic [3:0] opc, input logic [5:0] a, input logic [15:0] d);
        int unsigned n = 0;
        @(negedge clock);
        while (!(sel ? instr_ready2 : instr_ready) && n < 5000) begin @(negedge clock); n++; end
        check("issue_ready", 32'(sel ? instr_ready2 : instr_ready), 1);
        instr_opcode = opc; instr_addr = a; instr_data = d;
        if (sel) instr_valid2 = 1'b1;
        else     instr_valid  = 1'b1;
        t_acc = cyc;
        @(negedge clock);
        instr_valid = 1'b0; instr_valid2 = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, input string tag, input int unsigned exp_lat);
        int unsigned n = 0;
        while (!(sel ? instr_ready2 : instr_ready) && n < 5000) begin @(negedge clock); n++; end
        check({tag, "_timeout"}, 32'(n < 5000), 1);
        check({tag, "_latency"}, cyc - t_acc, exp_lat);
        check({tag, "_busy"}, 32'(sel ? busy2 : busy), 0);
        check({tag, "_queue_empty"}, sel ? exp2_q.size() : exp_q.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_instr_ready"}, 32'(instr_ready), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_strobes"}, {29'd0, mem_start, alu_start, mem_write_en}, 0);
        check({tag, "_buf"}, {25'd0, buf_id, buf_index}, 0);
        check({tag, "_alu_op"}, 32'(alu_op), 0);
        check({tag, "_mem_address"}, 32'(mem_address), 0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_dut2_idle"}, {30'd0, instr_ready2, busy2}, 32'h2);
    endtask

    initial begin
        int unsigned n;
        int unsigned nbuf;
        reset_n = 1'b0; instr_valid = 1'b0; instr_valid2 = 1'b0;
        instr_opcode = '0; instr_addr = '0; instr_data = '0;
        repeat (3) @(negedge clock);
        check_reset("reset");
        reset_n = 1'b1;

        // Spurious mem_done while idle
        @(negedge clock); mspur = 1'b1;
        @(negedge clock); mspur = 1'b0;
        check("spur_mem_ready", 32'(instr_ready), 1);
        check("spur_mem_busy_start", {30'd0, busy, mem_start}, 0);

        // STORE with a 3-cycle memory
        t_mem = 3;
        push_mem(0, 1'b1, 42, 0, 0, 1'b1, 16'hBEEF);
        issue(0, 4'd7, 6'h2A, 16'hBEEF);
        n = 0;
        while (mem_start && n < 50) begin
            check("store_we", 32'(mem_write_en), 1);
            check("store_addr", 32'(mem_address), 42);
            n++;
            @(negedge clock);
        end
        check("store_start_cycles", n, 3);
        check("store_we_dropped", 32'(mem_write_en), 0);
        wait_idle(0, "store", 4);

        // ALU op 1, zero-wait memory, 3-cycle ALU
        t_mem = 1; t_alu = 3;
        push_alu_seq(1, 2);
        issue(0, 4'd1, 6'h00, 16'h0);
        wait_idle(0, "alu1", 1 + 2 * 13 * 2 + 3 + 13 * 2);

        // Spurious alu_done during operand fetch, 3-cycle memory
        t_mem = 3; t_alu = 2;
        push_alu_seq(2, 2);
        issue(0, 4'd2, 6'h00, 16'h0);
        aspur = 1'b1;
        @(negedge clock); aspur = 1'b0;
        check("spur_alu_start", 32'(alu_start), 0);
        check("spur_alu_buf", {25'd0, buf_id, buf_index}, 0);
        check("spur_alu_mem_start", 32'(mem_start), 1);
        wait_idle(0, "alu2", 1 + 2 * 13 * 4 + 2 + 13 * 4);

        // Reset during the sixth dump word, then an immediate LOAD
        t_mem = 1; t_alu = 1;
        push_alu_seq(5, 2);
        issue(0, 4'd5, 6'h00, 16'h0);
        n = 0;
        while (!(mem_start && mem_write_en && buf_index == 5'd10) && n < 500) begin @(negedge clock); n++; end
        check("dump_word5_reached", 32'(n < 500), 1);
        reset_n = 1'b0;
        @(negedge clock);
        check_reset("mid_reset");
        exp_q.delete();
        reset_n = 1'b1;
        check("ready_after_reset", 32'(instr_ready), 1);
        push_mem(0, 1'b0, 9, 0, 0, 1'b0, 16'h0);
        issue(0, 4'd6, 6'd9, 16'h1234);
        wait_idle(0, "load", 2);

        // Opcode 3: unary skip only when the feature is built in
`ifdef MATSEQ_UNARY_SKIP_EN
        nbuf = 1;
`else
        nbuf = 2;
`endif
        t_mem = 1; t_alu = 2;
        push_alu_seq(3, nbuf);
        issue(0, 4'd3, 6'h00, 16'h0);
        wait_idle(0, "unary", 1 + nbuf * 13 * 2 + 2 + 13 * 2);

        // Second instance: 4 words per buffer, stride 8, three operands
        for (int unsigned b = 0; b < 3; b++)
            for (int unsigned w = 0; w < 4; w++)
                push_mem(1, 1'b0, b * 8 + w, b, w * 4, 1'b0, 16'h0);
        push_alu(1, 1);
        for (int unsigned w = 0; w < 4; w++)
            push_mem(1, 1'b1, 24 + w, 3, w * 4, 1'b0, 16'h0);
        issue(1, 4'd1, 6'h00, 16'h0);
        wait_idle(1, "dut2_alu", 1 + 3 * 4 * 2 + 1 + 4 * 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
